// File: rtl/multi_cycle_ctrl_if.sv
// Memory handshake bus between the control FSM and the shared memory port.
interface multi_cycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ack;

  modport master (output mem_req, output mem_we, output addr_sel, input mem_ack);
  modport slave  (input mem_req, input mem_we, input addr_sel, output mem_ack);
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I subset CPU: sequences fetch,
// decode, execute, memory and write-back, counts retired instructions and
// keeps sticky illegal/timeout flags. Strobes are combinational from state.
module multi_cycle_ctrl #(
  parameter int unsigned ADDR_WAIT_MAX = 255
) (
  input  logic                clk,
  input  logic                rstn,
  multi_cycle_ctrl_if.master  mem,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                zero,
  output logic                ir_we,
  output logic                mdr_we,
  output logic                pc_we,
  output logic [1:0]          pc_sel,
  output logic [1:0]          alu_a_sel,
  output logic [1:0]          alu_b_sel,
  output logic [1:0]          alu_op,
  output logic                aluout_we,
  output logic                rf_we,
  output logic [1:0]          wb_sel,
  output logic [2:0]          state,
  output logic                illegal,
  output logic                timeout,
  output logic [31:0]         instr_cnt
);

  localparam int WW = (ADDR_WAIT_MAX < 2) ? 1 : $clog2(ADDR_WAIT_MAX + 1);

  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef enum logic [2:0] {
    S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic            illegal_q, illegal_d;
  logic            timeout_q, timeout_d;
  logic [31:0]     instr_cnt_q, instr_cnt_d;
  logic [WW-1:0]   wait_q, wait_d;

  logic       req_c, we_c, asel_c, ir_we_c, mdr_we_c, pc_we_c, aluout_we_c, rf_we_c;
  logic [1:0] pc_sel_c, a_sel_c, b_sel_c, alu_op_c, wb_sel_c;
  logic       retire, op_legal, br_taken;

  // Strobe decode, next-state, flag and counter logic
  always_comb begin
    state_d     = state_q;
    illegal_d   = illegal_q;
    timeout_d   = timeout_q;
    wait_d      = wait_q;
    retire      = 1'b0;
    req_c       = 1'b0;
    we_c        = 1'b0;
    asel_c      = 1'b0;
    ir_we_c     = 1'b0;
    mdr_we_c    = 1'b0;
    pc_we_c     = 1'b0;
    pc_sel_c    = 2'd0;
    a_sel_c     = 2'd0;
    b_sel_c     = 2'd0;
    alu_op_c    = 2'd0;
    aluout_we_c = 1'b0;
    rf_we_c     = 1'b0;
    wb_sel_c    = 2'd0;
    br_taken    = (funct3 == 3'b000 && zero) || (funct3 == 3'b001 && !zero);

    case (opcode)
      OP_JAL, OP_BR, OP_LW, OP_SW, OP_ADDI, OP_R, OP_AUIPC, OP_JALR: op_legal = 1'b1;
      default:                                                       op_legal = 1'b0;
    endcase

    case (state_q)
      S_IF: begin
        req_c = 1'b1;
        if (mem.mem_ack) begin
          ir_we_c = 1'b1;
          state_d = S_ID;
        end
      end
      S_ID: begin
        // ALUOut = PC + imm, the branch/JAL target
        a_sel_c     = 2'd1;
        b_sel_c     = 2'd1;
        aluout_we_c = 1'b1;
        if (!op_legal || (opcode == OP_BR && funct3 != 3'b000 && funct3 != 3'b001)) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        case (opcode)
          OP_LW, OP_SW: begin
            b_sel_c = 2'd1; aluout_we_c = 1'b1; state_d = S_MEM;
          end
          OP_ADDI: begin
            b_sel_c = 2'd1; alu_op_c = 2'd2; aluout_we_c = 1'b1; state_d = S_WB;
          end
          OP_R: begin
            alu_op_c = 2'd2; aluout_we_c = 1'b1; state_d = S_WB;
          end
          OP_AUIPC: begin
            a_sel_c = 2'd1; b_sel_c = 2'd1; aluout_we_c = 1'b1; state_d = S_WB;
          end
          OP_BR: begin
            alu_op_c = 2'd1;
            pc_we_c  = 1'b1;
            pc_sel_c = br_taken ? 2'd1 : 2'd0;
            retire   = 1'b1;
            state_d  = S_IF;
          end
          OP_JAL: begin
            pc_we_c = 1'b1; pc_sel_c = 2'd1; state_d = S_WB;
          end
          OP_JALR: begin
            b_sel_c = 2'd1; pc_we_c = 1'b1; pc_sel_c = 2'd2; state_d = S_WB;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        req_c  = 1'b1;
        asel_c = 1'b1;
        we_c   = (opcode == OP_SW);
        if (mem.mem_ack) begin
          if (opcode == OP_SW) begin
            pc_we_c = 1'b1;
            retire  = 1'b1;
            state_d = S_IF;
          end else begin
            mdr_we_c = 1'b1;
            state_d  = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we_c = 1'b1;
        if (opcode == OP_LW)                           wb_sel_c = 2'd1;
        else if (opcode == OP_JAL || opcode == OP_JALR) wb_sel_c = 2'd2;
        if (opcode != OP_JAL && opcode != OP_JALR) pc_we_c = 1'b1;
        retire  = 1'b1;
        state_d = S_IF;
      end
      default: ;
    endcase

    // Unacknowledged request: the ack always wins over the timeout
    if (req_c && !mem.mem_ack && wait_q == WW'(ADDR_WAIT_MAX - 1)) begin
      timeout_d = 1'b1;
      state_d   = S_HALT;
    end

    // IF/MEM are only left on ack or timeout, so any state change clears it
    if (state_d != state_q)            wait_d = '0;
    else if (req_c && !mem.mem_ack)    wait_d = wait_q + 1'b1;

    instr_cnt_d = instr_cnt_q + {31'd0, retire};
  end

  // FSM state, sticky flags and counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IF;
      illegal_q   <= 1'b0;
      timeout_q   <= 1'b0;
      instr_cnt_q <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      illegal_q   <= illegal_d;
      timeout_q   <= timeout_d;
      instr_cnt_q <= instr_cnt_d;
      wait_q      <= wait_d;
    end
  end

  // Reset gates every strobe so an in-flight request drops immediately
  assign mem.mem_req  = rstn & req_c;
  assign mem.mem_we   = rstn & we_c;
  assign mem.addr_sel = rstn & asel_c;
  assign ir_we        = rstn & ir_we_c;
  assign mdr_we       = rstn & mdr_we_c;
  assign pc_we        = rstn & pc_we_c;
  assign aluout_we    = rstn & aluout_we_c;
  assign rf_we        = rstn & rf_we_c;
  assign pc_sel       = rstn ? pc_sel_c : 2'd0;
  assign alu_a_sel    = rstn ? a_sel_c  : 2'd0;
  assign alu_b_sel    = rstn ? b_sel_c  : 2'd0;
  assign alu_op       = rstn ? alu_op_c : 2'd0;
  assign wb_sel       = rstn ? wb_sel_c : 2'd0;

  assign state     = state_q;
  assign illegal   = illegal_q;
  assign timeout   = timeout_q;
  assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: each driven cycle pushes the
// expected control word; a monitor pops and compares mid-cycle.
module tb_multi_cycle_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  funct3 = 3'd0;
  logic        zero = 1'b0;
  logic        ir_we, mdr_we, pc_we, aluout_we, rf_we, illegal, timeout;
  logic [1:0]  pc_sel, alu_a_sel, alu_b_sel, alu_op, wb_sel;
  logic [2:0]  state;
  logic [31:0] instr_cnt;

  multi_cycle_ctrl_if bus ();

  multi_cycle_ctrl #(.ADDR_WAIT_MAX(4)) dut (
    .clk(clk), .rstn(rstn), .mem(bus), .opcode(opcode), .funct3(funct3), .zero(zero),
    .ir_we(ir_we), .mdr_we(mdr_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
    .aluout_we(aluout_we), .rf_we(rf_we), .wb_sel(wb_sel), .state(state),
    .illegal(illegal), .timeout(timeout), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        req, we, asel, irwe, mdrwe, pcwe;
    logic [1:0]  pcsel, asl, bsl, aop;
    logic        awe, rfwe;
    logic [1:0]  wbs;
    logic        ill, to;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  string       tag_q[$];
  int          n_tests = 0, n_fail = 0, ncyc = 0;
  logic [31:0] exp_cnt = 0;
  logic        exp_ill = 0, exp_to = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t obs();
    exp_t o;
    o.st = state; o.req = bus.mem_req; o.we = bus.mem_we; o.asel = bus.addr_sel;
    o.irwe = ir_we; o.mdrwe = mdr_we; o.pcwe = pc_we; o.pcsel = pc_sel;
    o.asl = alu_a_sel; o.bsl = alu_b_sel; o.aop = alu_op; o.awe = aluout_we;
    o.rfwe = rf_we; o.wbs = wb_sel; o.ill = illegal; o.to = timeout; o.cnt = instr_cnt;
    return o;
  endfunction

  function automatic exp_t base(input logic [2:0] st);
    exp_t e = '0;
    e.st = st; e.ill = exp_ill; e.to = exp_to; e.cnt = exp_cnt;
    return e;
  endfunction

  function automatic exp_t e_if(input logic ack);
    exp_t e = base(3'd0);
    e.req = 1'b1; e.irwe = ack;
    return e;
  endfunction

  function automatic exp_t e_id();
    exp_t e = base(3'd1);
    e.asl = 2'd1; e.bsl = 2'd1; e.awe = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_ex(input logic [1:0] a, input logic [1:0] b, input logic [1:0] op,
                                input logic awe, input logic pcwe, input logic [1:0] ps);
    exp_t e = base(3'd2);
    e.asl = a; e.bsl = b; e.aop = op; e.awe = awe; e.pcwe = pcwe; e.pcsel = ps;
    return e;
  endfunction

  function automatic exp_t e_mem(input logic sw, input logic ack);
    exp_t e = base(3'd3);
    e.req = 1'b1; e.asel = 1'b1; e.we = sw;
    e.pcwe = sw & ack; e.mdrwe = ~sw & ack;
    return e;
  endfunction

  function automatic exp_t e_wb(input logic [1:0] wbs, input logic pcwe);
    exp_t e = base(3'd4);
    e.rfwe = 1'b1; e.wbs = wbs; e.pcwe = pcwe;
    return e;
  endfunction

  // Drive one cycle's inputs at the negedge and queue its expectation
  task automatic cyc(input string tag, input logic ack, input logic z, input exp_t e);
    bus.mem_ack = ack;
    zero = z;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
  endtask

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3);
    opcode = op;
    funct3 = f3;
  endtask

  task automatic do_reset(input string tag);
    rstn = 1'b0;
    bus.mem_ack = 1'b0;
    exp_cnt = 0; exp_ill = 0; exp_to = 0;
    #3;
    chk(tag, {9'd0, obs()}, {9'd0, base(3'd0)});
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Monitor: compare the queued expectation mid-cycle
  initial begin
    exp_t e;
    string t;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk($sformatf("%s@%0d", t, ncyc), {9'd0, obs()}, {9'd0, e});
      end
      ncyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset("reset");

    // ADDI x1,x0,5 with ack held high throughout
    set_ir(7'b0010011, 3'b000);
    cyc("addi_if", 1, 0, e_if(1));
    cyc("addi_id", 1, 0, e_id());
    cyc("addi_ex", 1, 0, e_ex(2'd0, 2'd1, 2'd2, 1, 0, 2'd0));
    cyc("addi_wb", 1, 0, e_wb(2'd0, 1)); exp_cnt++;

    // LW with three data wait cycles
    set_ir(7'b0000011, 3'b010);
    cyc("lw_if", 1, 0, e_if(1));
    cyc("lw_id", 0, 0, e_id());
    cyc("lw_ex", 0, 0, e_ex(2'd0, 2'd1, 2'd0, 1, 0, 2'd0));
    repeat (3) cyc("lw_memw", 0, 0, e_mem(0, 0));
    cyc("lw_mema", 1, 0, e_mem(0, 1));
    cyc("lw_wb", 0, 0, e_wb(2'd1, 1)); exp_cnt++;

    // SW: one fetch wait, ack on the last wait cycle before timeout
    set_ir(7'b0100011, 3'b010);
    cyc("sw_ifw", 0, 0, e_if(0));
    cyc("sw_if", 1, 0, e_if(1));
    cyc("sw_id", 0, 0, e_id());
    cyc("sw_ex", 0, 0, e_ex(2'd0, 2'd1, 2'd0, 1, 0, 2'd0));
    repeat (3) cyc("sw_memw", 0, 0, e_mem(1, 0));
    cyc("sw_mema", 1, 0, e_mem(1, 1)); exp_cnt++;

    // Branches: BEQ taken / not taken, BNE taken
    set_ir(7'b1100011, 3'b000);
    cyc("beq1_if", 1, 0, e_if(1));
    cyc("beq1_id", 0, 1, e_id());
    cyc("beq1_ex", 0, 1, e_ex(2'd0, 2'd0, 2'd1, 0, 1, 2'd1)); exp_cnt++;
    cyc("beq0_if", 1, 0, e_if(1));
    cyc("beq0_id", 0, 0, e_id());
    cyc("beq0_ex", 0, 0, e_ex(2'd0, 2'd0, 2'd1, 0, 1, 2'd0)); exp_cnt++;
    set_ir(7'b1100011, 3'b001);
    cyc("bne_if", 1, 0, e_if(1));
    cyc("bne_id", 0, 0, e_id());
    cyc("bne_ex", 0, 0, e_ex(2'd0, 2'd0, 2'd1, 0, 1, 2'd1)); exp_cnt++;

    // JAL, JALR, R-type
    set_ir(7'b1101111, 3'b000);
    cyc("jal_if", 1, 0, e_if(1));
    cyc("jal_id", 0, 0, e_id());
    cyc("jal_ex", 0, 0, e_ex(2'd0, 2'd0, 2'd0, 0, 1, 2'd1));
    cyc("jal_wb", 0, 0, e_wb(2'd2, 0)); exp_cnt++;
    set_ir(7'b1100111, 3'b000);
    cyc("jalr_if", 1, 0, e_if(1));
    cyc("jalr_id", 0, 0, e_id());
    cyc("jalr_ex", 0, 0, e_ex(2'd0, 2'd1, 2'd0, 0, 1, 2'd2));
    cyc("jalr_wb", 0, 0, e_wb(2'd2, 0)); exp_cnt++;
    set_ir(7'b0110011, 3'b000);
    cyc("r_if", 1, 0, e_if(1));
    cyc("r_id", 0, 0, e_id());
    cyc("r_ex", 0, 0, e_ex(2'd0, 2'd0, 2'd2, 1, 0, 2'd0));
    cyc("r_wb", 0, 0, e_wb(2'd0, 1)); exp_cnt++;

    // Counter wrap: preset to all ones during a fetch wait, retire AUIPC
    set_ir(7'b0010111, 3'b000);
    bus.mem_ack = 1'b0;
    force dut.instr_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.instr_cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    cyc("auipc_if", 1, 0, e_if(1));
    cyc("auipc_id", 0, 0, e_id());
    cyc("auipc_ex", 0, 0, e_ex(2'd1, 2'd1, 2'd0, 1, 0, 2'd0));
    cyc("auipc_wb", 0, 0, e_wb(2'd0, 1)); exp_cnt++;
    cyc("wrap_if", 0, 0, e_if(0));
    cyc("wrap_if2", 1, 0, e_if(1));

    // Mid-request reset during MEM of an LW
    set_ir(7'b0000011, 3'b010);
    cyc("mid_id", 0, 0, e_id());
    cyc("mid_ex", 0, 0, e_ex(2'd0, 2'd1, 2'd0, 1, 0, 2'd0));
    bus.mem_ack = 1'b0;
    #1;
    chk("mid_req_on", {63'd0, bus.mem_req}, 64'd1);
    rstn = 1'b0;
    #1;
    chk("mid_req_drop", {63'd0, bus.mem_req}, 64'd0);
    chk("mid_state", {61'd0, state}, 64'd0);
    exp_cnt = 0;
    @(negedge clk);
    rstn = 1'b1;
    cyc("mid_after", 0, 0, e_if(0));
    do_reset("reset2");

    // Illegal opcode 0x7F: halt with all strobes low, ack ignored
    set_ir(7'h7F, 3'b000);
    cyc("ill_if", 1, 0, e_if(1));
    cyc("ill_id", 1, 0, e_id()); exp_ill = 1;
    repeat (10) cyc("ill_halt", 1, 0, base(3'd5));
    do_reset("ill_clr");

    // Branch with funct3 = 010
    set_ir(7'b1100011, 3'b010);
    cyc("illb_if", 1, 0, e_if(1));
    cyc("illb_id", 0, 0, e_id()); exp_ill = 1;
    repeat (2) cyc("illb_halt", 0, 0, base(3'd5));
    do_reset("illb_clr");

    // Fetch timeout after four unacknowledged cycles
    set_ir(7'b0010011, 3'b000);
    repeat (4) cyc("to_if", 0, 0, e_if(0));
    exp_to = 1;
    repeat (3) cyc("to_halt", 1, 0, base(3'd5));
    do_reset("to_clr");

    #3;
    if (exp_q.size() != 0) chk("queue_drain", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
